apb_master: RTL and testbench

Single-channel APB4 initiator that converts a valid/ready command interface into APB SETUP/ACCESS transfers and returns one response per command. It drives the request side of the APB subsystem toward the slave demux and consumes the response triple (pready/prdata/pslverr) that the slave-side mux merges back. A programmable ACCESS-phase timeout guarantees forward progress when no slave answers.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master.sv | 143 ++++++++++++++
 tb/tb_apb_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB subsystem types: FSM state encoding and strobe-width helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   function automatic int unsigned strb_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned STRB_WIDTH         = strb_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/apb_master.sv
// Single-channel APB4 initiator: valid/ready commands in, SETUP/ACCESS transfers out,
// one registered response pulse per command, with an optional ACCESS-phase timeout.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // command side
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic                    cmd_write_i,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
   // response side
   output logic                    rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   // APB request
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   // merged APB response
   input  logic                    pready_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pslverr_i
);

   localparam int unsigned StrbW = strb_width(DATA_WIDTH);
   // Keep at least one counter bit so TIMEOUT_CYCLES = 0 still elaborates.
   localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] TimeoutLimit = CntW'(TIMEOUT_CYCLES);
   localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

   apb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic                   pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic [StrbW-1:0]       pstrb_q, pstrb_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;

   logic [CntW-1:0]        cnt_inc;
   logic                   timeout_hit;

   assign cnt_inc     = cnt_q + CntW'(1);
   // Fires in the ACCESS cycle whose missing pready would bring the count to the limit.
   assign timeout_hit = TimeoutEn && (cnt_inc == TimeoutLimit);

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               paddr_d  = cmd_addr_i;
               pwrite_d = cmd_write_i;
               pwdata_d = cmd_wdata_i;
               pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr_i;
               rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
               state_d     = IDLE;
            end else if (timeout_hit) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Handshake and APB control come straight from the registered state.
   assign cmd_ready_o = (state_q == IDLE);
   assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable_o   = (state_q == ACCESS);

   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign pstrb_o     = pstrb_q;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT_CYCLES = 4) with hand-computed expectations.
module tb_apb_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [31:0] cmd_addr_i;
   logic        cmd_write_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_strb_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic        pready_i;
   logic [31:0] prdata_i;
   logic        pslverr_i;

   int checks   = 0;
   int failures = 0;
   int rsp_cnt;

   always #5 clk_i = ~clk_i;

   apb_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i (cmd_addr_i),
      .cmd_write_i(cmd_write_i),
      .cmd_wdata_i(cmd_wdata_i),
      .cmd_strb_i (cmd_strb_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o  (rsp_err_o),
      .psel_o     (psel_o),
      .penable_o  (penable_o),
      .pwrite_o   (pwrite_o),
      .paddr_o    (paddr_o),
      .pwdata_o   (pwdata_o),
      .pstrb_o    (pstrb_o),
      .pready_i   (pready_i),
      .prdata_i   (prdata_i),
      .pslverr_i  (pslverr_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] strb);
      cmd_valid_i = 1'b1;
      cmd_addr_i  = addr;
      cmd_write_i = wr;
      cmd_wdata_i = wd;
      cmd_strb_i  = strb;
   endtask

   initial begin
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_write_i = 1'b0;
      cmd_wdata_i = '0;
      cmd_strb_i  = '0;
      pready_i    = 1'b0;
      prdata_i    = '0;
      pslverr_i   = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("rst_psel", {31'd0, psel_o}, 32'd0);
      chk("rst_penable", {31'd0, penable_o}, 32'd0);
      chk("rst_pwrite", {31'd0, pwrite_o}, 32'd0);
      chk("rst_paddr", paddr_o, 32'd0);
      chk("rst_pwdata", pwdata_o, 32'd0);
      chk("rst_pstrb", {28'd0, pstrb_o}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      rst_i = 1'b0;
      tick();

      // Zero-wait read; nonzero command strobe must not reach pstrb_o
      send(32'h0000_0010, 1'b0, 32'hAAAA_5555, 4'hF);
      tick();
      cmd_valid_i = 1'b0;
      chk("rd_setup_psel", {31'd0, psel_o}, 32'd1);
      chk("rd_setup_penable", {31'd0, penable_o}, 32'd0);
      chk("rd_setup_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      chk("rd_paddr", paddr_o, 32'h0000_0010);
      chk("rd_pwrite", {31'd0, pwrite_o}, 32'd0);
      chk("rd_pstrb", {28'd0, pstrb_o}, 32'd0);
      pready_i = 1'b1;
      prdata_i = 32'hDEAD_BEEF;
      tick();
      chk("rd_access_penable", {31'd0, penable_o}, 32'd1);
      chk("rd_access_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      tick();
      pready_i = 1'b0;
      chk("rd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("rd_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      chk("rd_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      chk("rd_rsp_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("rd_rsp_psel", {31'd0, psel_o}, 32'd0);
      tick();
      chk("rd_pulse_end", {31'd0, rsp_valid_o}, 32'd0);
      chk("rd_rdata_hold", rsp_rdata_o, 32'hDEAD_BEEF);

      // Write with 3 wait states; command inputs change but must be ignored
      send(32'h0000_0020, 1'b1, 32'h1234_5678, 4'h3);
      tick();
      cmd_valid_i = 1'b0;
      cmd_addr_i  = 32'hFFFF_FFFF;
      cmd_wdata_i = 32'h0;
      cmd_strb_i  = 4'hC;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr_penable", {31'd0, penable_o}, 32'd1);
         chk("wr_paddr", paddr_o, 32'h0000_0020);
         chk("wr_pwdata", pwdata_o, 32'h1234_5678);
         chk("wr_pstrb", {28'd0, pstrb_o}, 32'h3);
         chk("wr_pwrite", {31'd0, pwrite_o}, 32'd1);
         chk("wr_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
         pready_i = (i == 3);
         prdata_i = 32'h5555_AAAA;
      end
      tick();
      pready_i = 1'b0;
      chk("wr_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("wr_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("wr_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      chk("wr_idle_paddr_hold", paddr_o, 32'h0000_0020);

      // Read answered with pslverr
      send(32'h0000_0030, 1'b0, 32'h0, 4'h0);
      tick();
      cmd_valid_i = 1'b0;
      pready_i    = 1'b1;
      pslverr_i   = 1'b1;
      prdata_i    = 32'hFFFF_FFFF;
      tick();
      tick();
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      chk("err_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("err_rsp_err", {31'd0, rsp_err_o}, 32'd1);
      chk("err_rsp_rdata", rsp_rdata_o, 32'd0);

      // pready on the 4th ACCESS cycle beats the timeout
      send(32'h0000_0050, 1'b0, 32'h0, 4'h0);
      tick();
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("late_psel", {31'd0, psel_o}, 32'd1);
         chk("late_penable", {31'd0, penable_o}, 32'd1);
         pready_i = (i == 3);
         prdata_i = 32'h0BAD_F00D;
      end
      tick();
      pready_i = 1'b0;
      chk("late_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("late_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      chk("late_rsp_rdata", rsp_rdata_o, 32'h0BAD_F00D);

      // No pready at all: forced error after 4 ACCESS cycles
      send(32'h0000_0040, 1'b0, 32'h0, 4'h0);
      tick();
      cmd_valid_i = 1'b0;
      prdata_i    = 32'h1111_1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_penable", {31'd0, penable_o}, 32'd1);
         chk("to_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end
      tick();
      chk("to_psel_drop", {31'd0, psel_o}, 32'd0);
      chk("to_penable_drop", {31'd0, penable_o}, 32'd0);
      chk("to_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("to_rsp_err", {31'd0, rsp_err_o}, 32'd1);
      chk("to_rsp_rdata", rsp_rdata_o, 32'd0);

      // cmd_valid held high: accepts every 3 cycles, exactly 3 responses
      rsp_cnt  = 0;
      pready_i = 1'b1;
      prdata_i = 32'h0;
      send(32'h0000_0100, 1'b1, 32'hCAFE_0000, 4'hF);
      for (int c = 0; c < 9; c++) begin
         tick();
         chk("b2b_cmd_ready", {31'd0, cmd_ready_o}, {31'd0, (c % 3) == 2});
         chk("b2b_psel", {31'd0, psel_o}, {31'd0, (c % 3) != 2});
         if (rsp_valid_o) rsp_cnt++;
         if (c == 8) cmd_valid_i = 1'b0;
      end
      tick();
      if (rsp_valid_o) rsp_cnt++;
      chk("b2b_rsp_count", rsp_cnt, 32'd3);
      chk("b2b_no_4th", {31'd0, psel_o}, 32'd0);
      pready_i = 1'b0;

      // Reset during ACCESS
      send(32'h0000_0060, 1'b0, 32'h0, 4'h0);
      tick();
      cmd_valid_i = 1'b0;
      tick();
      chk("mid_access_penable", {31'd0, penable_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_psel", {31'd0, psel_o}, 32'd0);
      chk("mid_rst_penable", {31'd0, penable_o}, 32'd0);
      chk("mid_rst_paddr", paddr_o, 32'd0);
      chk("mid_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("mid_rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      tick();
      rst_i = 1'b0;
      tick();
      chk("post_rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      send(32'h0000_0070, 1'b1, 32'h8765_4321, 4'h5);
      tick();
      cmd_valid_i = 1'b0;
      chk("post_rst_paddr", paddr_o, 32'h0000_0070);
      chk("post_rst_pstrb", {28'd0, pstrb_o}, 32'h5);
      pready_i = 1'b1;
      tick();
      tick();
      pready_i = 1'b0;
      chk("post_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("post_rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      chk("post_rst_rsp_rdata", rsp_rdata_o, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
